// File: rtl/clock_divider_prog.sv
// Multi-channel runtime-programmable clock divider with per-channel 50% clock and rising-edge tick.
// Optional CLKDIV_PHASE_SYNC_EN adds a sync_all input that realigns every enabled channel.
module clock_divider_prog #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned CH_SEL_W     = 2,
  parameter int unsigned DEFAULT_HALF = 25
) (
  input  logic                 CLK6_25MHZ,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    ch_en,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic                 sync_all,
`endif
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_SEL_W-1:0]  cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_half,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick
);

  localparam logic [DIV_WIDTH-1:0] DefHalf = DIV_WIDTH'(DEFAULT_HALF);

  logic [DIV_WIDTH-1:0] cnt_q    [NUM_CH];
  logic [DIV_WIDTH-1:0] cnt_d    [NUM_CH];
  logic [DIV_WIDTH-1:0] half_q   [NUM_CH];
  logic [DIV_WIDTH-1:0] half_d   [NUM_CH];
  logic [DIV_WIDTH-1:0] shadow_q [NUM_CH];
  logic [DIV_WIDTH-1:0] shadow_d [NUM_CH];
  logic [NUM_CH-1:0]    pend_q, pend_d;
  logic [NUM_CH-1:0]    clk_q, clk_d;
  logic [NUM_CH-1:0]    tick_q, tick_d;
  logic                 sync;
  logic                 cfg_fire;

`ifdef CLKDIV_PHASE_SYNC_EN
  assign sync = sync_all;
`else
  assign sync = 1'b0;
`endif

  // Out-of-range channel indices are always ready so the source never stalls on them.
  always_comb begin
    cfg_ready = 1'b0;
    if (!reset) begin
      if (32'(cfg_ch) >= NUM_CH) begin
        cfg_ready = 1'b1;
      end else begin
        cfg_ready = ~pend_q[cfg_ch];
      end
    end
  end

  assign cfg_fire = cfg_valid & cfg_ready;

  always_comb begin
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      half_d[i]   = half_q[i];
      shadow_d[i] = shadow_q[i];
      if (!ch_en[i] || sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pend_q[i]) begin
          half_d[i] = shadow_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (cnt_q[i] == half_q[i]) begin
        // Boundary: toggle on the old count, new count governs the next half-period.
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = ~clk_q[i];
        if (pend_q[i]) begin
          half_d[i] = shadow_q[i];
          pend_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
      end
      // A transfer only happens with pend_q clear, so it never races the apply above.
      if (cfg_fire && (32'(cfg_ch) == i)) begin
        shadow_d[i] = cfg_half;
        pend_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK6_25MHZ) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        half_q[i]   <= DefHalf;
        shadow_q[i] <= '0;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule
